seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator, latched on accepted start.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator, latched on accepted start.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: quotient  output  WIDTH  result quotient.
REQ-010 SHALL have port: remainder  output  WIDTH  result remainder.
REQ-011 SHALL have port: div0  output  1  divisor-zero flag, valid with done.

Function
REQ-012 SHALL implement unsigned restoring division: one quotient bit per clock, MSB first.
REQ-013 SHALL use FSM states IDLE, RUN, DONE.
REQ-014 IDLE -> RUN when start=1: latch operands; clear partial remainder (WIDTH+1 bits); load iteration counter with WIDTH-1.
REQ-015 RUN, each cycle: shift {rem, dividend MSB} left; trial subtract divisor; keep the difference and set the q bit when non-negative, else restore and clear the q bit.
REQ-016 RUN -> DONE after exactly WIDTH iterations; the counter decrements once per RUN cycle.
REQ-017 DONE lasts one cycle: done=1 and busy=0; quotient, remainder and div0 updated on entry to DONE; DONE -> IDLE unconditionally.
REQ-018 Latency: start sampled at edge N -> done high during cycle N+WIDTH+1 (cycle 9 for WIDTH=8).
REQ-019 busy SHALL be 1 exactly in RUN.
REQ-020 start while busy or in DONE SHALL be ignored; no queuing.
REQ-021 quotient, remainder and div0 SHALL hold their last values through IDLE until the next DONE.
REQ-022 Operand input changes after the accepting edge SHALL NOT affect the result.
REQ-023 dividend < divisor -> quotient 0, remainder = dividend.

Reset
REQ-024 rst=1 at a clock edge -> state IDLE; busy=0, done=0, div0=0, quotient=0, remainder=0, counter=0.
REQ-025 rst SHALL take priority over start and over any in-flight division; the aborted operation produces no done.
REQ-026 start asserted in the same cycle as rst SHALL be dropped.

Configuration
REQ-027 Macro SEQ_DIVIDER_DIV0_DETECT_EN SHALL control divide-by-zero detection.
REQ-028 With the macro defined, divisor=0 on start -> skip RUN and go IDLE -> DONE; done one cycle after acceptance; div0=1; quotient = all ones; remainder = dividend.
REQ-029 With the macro undefined, divisor=0 runs the full WIDTH iterations (natural result: quotient all ones, remainder = dividend); div0 is tied to 0; the port remains present.

Structure
REQ-030 Shared package seq_divider_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default-width constant.
REQ-031 Sub-module div_step SHALL be combinational: a (WIDTH+1)-bit trial subtract/restore taking partial remainder, next dividend bit and divisor, and returning next remainder and quotient bit; seq_divider instantiates it once.

Verification
REQ-032 Bench: dividend=200, divisor=7, start at one edge -> 8 busy cycles, then done; quotient=28, remainder=4, div0=0.
REQ-033 Bench: 0xFF/0x01 -> quotient=0xFF, remainder=0x00; 0x05/0x09 -> quotient=0x00, remainder=0x05; 0x6C/0x0A -> quotient=0x0A, remainder=0x08.
REQ-034 Bench: 0x55/0x00 with the macro -> done one cycle after acceptance, div0=1, quotient=0xFF, remainder=0x55; without the macro -> done after 9 cycles, same quotient/remainder, div0=0.
REQ-035 Bench: start 100/3, then pulse start with 50/5 during RUN -> second start ignored; single done with quotient=33, remainder=1.
REQ-036 Bench: assert rst in the 4th RUN cycle -> next cycle busy=0, all outputs 0, no done; a following start 9/2 -> quotient=4, remainder=1.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module : seq_divider_pkg
// Brief  : Shared FSM state encoding and default operand width for seq_divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    localparam int unsigned C_DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_divider_pkg

`default_nettype wire

// File: rtl/seq_divider_div_step.sv
// ============================================================================
// Module : div_step
// Brief  : One combinational restoring-division step (trial subtract/restore).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {1'b0, i_dvs};

    // The partial remainder is always below the divisor, so the top bit of the
    // (WIDTH+1)-bit difference is a clean borrow flag.
    assign o_q   = ~w_diff[WIDTH];
    assign o_rem = o_q ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule : div_step

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module : seq_divider
// Brief  : Sequential unsigned restoring divider, one quotient bit per clock.
//          Define SEQ_DIVIDER_DIV0_DETECT_EN for the divide-by-zero shortcut.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dq;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic [WIDTH-1:0]   w_rem_next;
    logic               w_qbit;
    logic [WIDTH:0]     w_dq_shift;
    logic               w_div0_start;

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem (r_rem),
        .i_bit (r_dq[WIDTH-1]),
        .i_dvs (r_dvs),
        .o_rem (w_rem_next),
        .o_q   (w_qbit)
    );

    // r_dq shifts dividend bits out of the MSB while quotient bits enter the LSB.
    assign w_dq_shift = {r_dq, w_qbit};

`ifdef SEQ_DIVIDER_DIV0_DETECT_EN
    assign w_div0_start = (divisor == '0);
`else
    assign w_div0_start = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_div0_start ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_dq        <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dq  <= dividend;
                        r_dvs <= divisor;
                        r_rem <= '0;
                        r_cnt <= CNT_W'(WIDTH - 1);
                        if (w_div0_start) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end
                    end
                end
                RUN: begin
                    r_dq  <= w_dq_shift[WIDTH-1:0];
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_quotient  <= w_dq_shift[WIDTH-1:0];
                        r_remainder <= w_rem_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

`ifdef SEQ_DIVIDER_DIV0_DETECT_EN
    logic r_div0;

    // DONE is reached straight from IDLE only through the zero-divisor shortcut.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div0 <= 1'b0;
        end else if (w_state_next == DONE && r_state != DONE) begin
            r_div0 <= (r_state == IDLE);
        end
    end

    assign div0 = r_div0;
`else
    assign div0 = 1'b0;
`endif

endmodule : seq_divider

`default_nettype wire
